// File: rtl/holy_axi_pkg.sv
// Shared types for the HOLY AXI-Lite interconnect blocks.
package holy_axi_pkg;

  // Width of the AXI bresp/rresp field.
  localparam int unsigned RespW = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrXfer,
    StWrResp
  } arb_state_t;

endpackage

// File: rtl/holy_axi_lite_arbiter.sv
// Two-requester AXI-Lite arbiter: requester 0 is the core data path, requester 1 the
// debug module. One transaction in flight at a time; round-robin on ties, reads first.
module holy_axi_lite_arbiter
  import holy_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Requester 0
  input  logic [ADDR_W-1:0]     s0_awaddr,
  input  logic                  s0_awvalid,
  output logic                  s0_awready,
  input  logic [DATA_W-1:0]     s0_wdata,
  input  logic [DATA_W/8-1:0]   s0_wstrb,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  output logic [RespW-1:0]      s0_bresp,
  output logic                  s0_bvalid,
  input  logic                  s0_bready,
  input  logic [ADDR_W-1:0]     s0_araddr,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_W-1:0]     s0_rdata,
  output logic [RespW-1:0]      s0_rresp,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  // Requester 1
  input  logic [ADDR_W-1:0]     s1_awaddr,
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [DATA_W-1:0]     s1_wdata,
  input  logic [DATA_W/8-1:0]   s1_wstrb,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  output logic [RespW-1:0]      s1_bresp,
  output logic                  s1_bvalid,
  input  logic                  s1_bready,
  input  logic [ADDR_W-1:0]     s1_araddr,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_W-1:0]     s1_rdata,
  output logic [RespW-1:0]      s1_rresp,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  // Downstream master
  output logic [ADDR_W-1:0]     m_axi_lite_awaddr,
  output logic                  m_axi_lite_awvalid,
  input  logic                  m_axi_lite_awready,
  output logic [DATA_W-1:0]     m_axi_lite_wdata,
  output logic [DATA_W/8-1:0]   m_axi_lite_wstrb,
  output logic                  m_axi_lite_wvalid,
  input  logic                  m_axi_lite_wready,
  input  logic [RespW-1:0]      m_axi_lite_bresp,
  input  logic                  m_axi_lite_bvalid,
  output logic                  m_axi_lite_bready,
  output logic [ADDR_W-1:0]     m_axi_lite_araddr,
  output logic                  m_axi_lite_arvalid,
  input  logic                  m_axi_lite_arready,
  input  logic [DATA_W-1:0]     m_axi_lite_rdata,
  input  logic [RespW-1:0]      m_axi_lite_rresp,
  input  logic                  m_axi_lite_rvalid,
  output logic                  m_axi_lite_rready,
  // Status
  output logic                  busy,
  output logic                  grant_id
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_id_q, last_id_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  // Request signals of the granted requester.
  logic [ADDR_W-1:0]   g_awaddr, g_araddr;
  logic [DATA_W-1:0]   g_wdata;
  logic [DATA_W/8-1:0] g_wstrb;
  logic                g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  // Return signals toward the granted requester.
  logic                g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic [RespW-1:0]    g_bresp, g_rresp;
  logic [DATA_W-1:0]   g_rdata;

  logic cand0, cand1, pick, pick_rd;

  // State and per-transaction bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_id_q <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_id_q <= last_id_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Select the granted requester's request signals.
  always_comb begin
    g_awaddr  = grant_q ? s1_awaddr  : s0_awaddr;
    g_awvalid = grant_q ? s1_awvalid : s0_awvalid;
    g_wdata   = grant_q ? s1_wdata   : s0_wdata;
    g_wstrb   = grant_q ? s1_wstrb   : s0_wstrb;
    g_wvalid  = grant_q ? s1_wvalid  : s0_wvalid;
    g_bready  = grant_q ? s1_bready  : s0_bready;
    g_araddr  = grant_q ? s1_araddr  : s0_araddr;
    g_arvalid = grant_q ? s1_arvalid : s0_arvalid;
    g_rready  = grant_q ? s1_rready  : s0_rready;
  end

  // Round-robin pick: on a tie the requester that did not finish last wins.
  always_comb begin
    cand0   = s0_arvalid | s0_awvalid;
    cand1   = s1_arvalid | s1_awvalid;
    pick    = (cand0 && cand1) ? ~last_id_q : cand1;
    pick_rd = pick ? s1_arvalid : s0_arvalid;
  end

  // Next state and phase-gated forwarding; everything idles at zero outside its phase.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_id_d = last_id_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    m_axi_lite_awaddr  = '0;
    m_axi_lite_awvalid = 1'b0;
    m_axi_lite_wdata   = '0;
    m_axi_lite_wstrb   = '0;
    m_axi_lite_wvalid  = 1'b0;
    m_axi_lite_bready  = 1'b0;
    m_axi_lite_araddr  = '0;
    m_axi_lite_arvalid = 1'b0;
    m_axi_lite_rready  = 1'b0;

    g_awready = 1'b0;
    g_wready  = 1'b0;
    g_bresp   = '0;
    g_bvalid  = 1'b0;
    g_arready = 1'b0;
    g_rdata   = '0;
    g_rresp   = '0;
    g_rvalid  = 1'b0;

    case (state_q)
      StIdle: begin
        if (cand0 || cand1) begin
          grant_d = pick;
          state_d = pick_rd ? StRdAddr : StWrXfer;
        end
      end
      StRdAddr: begin
        m_axi_lite_araddr  = g_araddr;
        m_axi_lite_arvalid = g_arvalid;
        g_arready          = m_axi_lite_arready;
        if (g_arvalid && m_axi_lite_arready) state_d = StRdData;
      end
      StRdData: begin
        m_axi_lite_rready = g_rready;
        g_rdata           = m_axi_lite_rdata;
        g_rresp           = m_axi_lite_rresp;
        g_rvalid          = m_axi_lite_rvalid;
        if (m_axi_lite_rvalid && g_rready) begin
          state_d   = StIdle;
          last_id_d = grant_q;
        end
      end
      StWrXfer: begin
        // Each channel is masked once its handshake has happened, so neither repeats.
        m_axi_lite_awaddr  = g_awaddr;
        m_axi_lite_awvalid = g_awvalid & ~aw_done_q;
        g_awready          = m_axi_lite_awready & ~aw_done_q;
        m_axi_lite_wdata   = g_wdata;
        m_axi_lite_wstrb   = g_wstrb;
        m_axi_lite_wvalid  = g_wvalid & ~w_done_q;
        g_wready           = m_axi_lite_wready & ~w_done_q;
        aw_done_d = aw_done_q | (m_axi_lite_awvalid & m_axi_lite_awready);
        w_done_d  = w_done_q | (m_axi_lite_wvalid & m_axi_lite_wready);
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        m_axi_lite_bready = g_bready;
        g_bresp           = m_axi_lite_bresp;
        g_bvalid          = m_axi_lite_bvalid;
        if (m_axi_lite_bvalid && g_bready) begin
          state_d   = StIdle;
          last_id_d = grant_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Route returns to the granted requester only; the other side sees zeros.
  always_comb begin
    s0_awready = grant_q ? 1'b0 : g_awready;
    s0_wready  = grant_q ? 1'b0 : g_wready;
    s0_bresp   = grant_q ? '0   : g_bresp;
    s0_bvalid  = grant_q ? 1'b0 : g_bvalid;
    s0_arready = grant_q ? 1'b0 : g_arready;
    s0_rdata   = grant_q ? '0   : g_rdata;
    s0_rresp   = grant_q ? '0   : g_rresp;
    s0_rvalid  = grant_q ? 1'b0 : g_rvalid;
    s1_awready = grant_q ? g_awready : 1'b0;
    s1_wready  = grant_q ? g_wready  : 1'b0;
    s1_bresp   = grant_q ? g_bresp   : '0;
    s1_bvalid  = grant_q ? g_bvalid  : 1'b0;
    s1_arready = grant_q ? g_arready : 1'b0;
    s1_rdata   = grant_q ? g_rdata   : '0;
    s1_rresp   = grant_q ? g_rresp   : '0;
    s1_rvalid  = grant_q ? g_rvalid  : 1'b0;
    busy       = (state_q != StIdle);
    grant_id   = grant_q;
  end

endmodule

// File: tb/tb_holy_axi_lite_arbiter.sv
// Bench for holy_axi_lite_arbiter: reactive downstream slave, table of single
// transactions, plus tie, split-write and reset-in-flight sequences.
module tb_holy_axi_lite_arbiter;

  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [1:0]  s0_bresp, s0_rresp;
  logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [1:0]  s1_bresp, s1_rresp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;
  logic        busy, grant_id;

  holy_axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_axi_lite_awaddr(m_awaddr), .m_axi_lite_awvalid(m_awvalid),
    .m_axi_lite_awready(m_awready), .m_axi_lite_wdata(m_wdata), .m_axi_lite_wstrb(m_wstrb),
    .m_axi_lite_wvalid(m_wvalid), .m_axi_lite_wready(m_wready), .m_axi_lite_bresp(m_bresp),
    .m_axi_lite_bvalid(m_bvalid), .m_axi_lite_bready(m_bready),
    .m_axi_lite_araddr(m_araddr), .m_axi_lite_arvalid(m_arvalid),
    .m_axi_lite_arready(m_arready), .m_axi_lite_rdata(m_rdata), .m_axi_lite_rresp(m_rresp),
    .m_axi_lite_rvalid(m_rvalid), .m_axi_lite_rready(m_rready),
    .busy(busy), .grant_id(grant_id)
  );

  int checks, errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake not seen within cycle budget", name);
  endtask

  // ---------------- downstream slave model ----------------
  int          aw_delay, w_delay, aw_wait, w_wait, n_ar, n_aw, n_w;
  logic [1:0]  cfg_bresp, cfg_rresp, bresp_q, rresp_q;
  logic [31:0] cfg_rdata, rdata_q, cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        aw_got, w_got, arready_q, rvalid_q, bvalid_q;

  assign m_awready = m_awvalid && (aw_wait >= aw_delay);
  assign m_wready  = m_wvalid && (w_wait >= w_delay);
  assign m_arready = arready_q;
  assign m_rvalid  = rvalid_q;
  assign m_rdata   = rdata_q;
  assign m_rresp   = rresp_q;
  assign m_bvalid  = bvalid_q;
  assign m_bresp   = bresp_q;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      arready_q <= 1'b0; rvalid_q <= 1'b0; bvalid_q <= 1'b0;
      rdata_q <= '0; rresp_q <= '0; bresp_q <= '0;
    end else begin
      if (m_awvalid && !m_awready) aw_wait <= aw_wait + 1;
      if (m_wvalid && !m_wready) w_wait <= w_wait + 1;
      if (m_awvalid && m_awready) begin
        aw_wait <= 0; n_aw <= n_aw + 1; cap_awaddr <= m_awaddr;
      end
      if (m_wvalid && m_wready) begin
        w_wait <= 0; n_w <= n_w + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb;
      end
      if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready))) begin
        bvalid_q <= 1'b1; bresp_q <= cfg_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (m_awvalid && m_awready) aw_got <= 1'b1;
        if (m_wvalid && m_wready) w_got <= 1'b1;
      end
      if (bvalid_q && m_bready) bvalid_q <= 1'b0;
      // arready rises one cycle after arvalid is seen
      if (arready_q) arready_q <= 1'b0;
      else if (m_arvalid && !rvalid_q) arready_q <= 1'b1;
      if (m_arvalid && arready_q) begin
        rvalid_q <= 1'b1; rdata_q <= cfg_rdata; rresp_q <= cfg_rresp;
        cap_araddr <= m_araddr; n_ar <= n_ar + 1;
      end
      if (rvalid_q && m_rready) rvalid_q <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int   busy_cnt;
  logic busy_prev;
  logic glog[$];
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (busy && !busy_prev) glog.push_back(grant_id);
    busy_prev <= busy;
  end

  // Requester-side valids must be held until their ready.
  logic [3:0] vld_v, rdy_v, pend_q;
  assign vld_v = {s1_awvalid, s1_arvalid, s0_awvalid, s0_arvalid};
  assign rdy_v = {s1_awready, s1_arready, s0_awready, s0_arready};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!rst && pend_q[i]) assert (vld_v[i]) else $error("protocol: valid %0d dropped early", i);
    pend_q <= rst ? 4'b0 : (vld_v & ~rdy_v);
  end

  // ---------------- helpers ----------------
  function automatic logic [40:0] side_out(input int id);
    if (id == 0)
      return {s0_awready, s0_wready, s0_bresp, s0_bvalid, s0_arready, s0_rdata, s0_rresp,
              s0_rvalid};
    return {s1_awready, s1_wready, s1_bresp, s1_bvalid, s1_arready, s1_rdata, s1_rresp,
            s1_rvalid};
  endfunction

  function automatic logic any_out();
    return |{busy, grant_id, side_out(0), side_out(1), m_awaddr, m_awvalid, m_wdata, m_wstrb,
             m_wvalid, m_bready, m_araddr, m_arvalid, m_rready};
  endfunction

  task automatic set_ar(input int id, input logic v, input logic [31:0] a);
    if (id == 0) begin s0_arvalid = v; s0_araddr = a; end
    else begin s1_arvalid = v; s1_araddr = a; end
  endtask

  task automatic set_rready(input int id, input logic v);
    if (id == 0) s0_rready = v; else s1_rready = v;
  endtask

  task automatic do_read(input int id, input logic [31:0] addr, input bit chk_other,
                         output logic [31:0] data, output logic [1:0] resp, output logic gnt,
                         output bit ok);
    ok = 1'b0; data = '0; resp = '0; gnt = 1'b0;
    set_ar(id, 1'b1, addr);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (chk_other) check("rd_other_side_quiet", side_out(1 - id), 0);
      if ((id == 0) ? s0_arready : s1_arready) begin
        gnt = grant_id; ok = 1'b1; break;
      end
    end
    @(posedge clk); #1;
    set_ar(id, 1'b0, '0);
    if (!ok) begin note_timeout("rd_ar"); return; end
    ok = 1'b0;
    set_rready(id, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (chk_other) check("rd_other_side_quiet", side_out(1 - id), 0);
      if ((id == 0) ? s0_rvalid : s1_rvalid) begin
        data = (id == 0) ? s0_rdata : s1_rdata;
        resp = (id == 0) ? s0_rresp : s1_rresp;
        ok = 1'b1; break;
      end
    end
    @(posedge clk); #1;
    set_rready(id, 1'b0);
    if (!ok) note_timeout("rd_r");
  endtask

  task automatic set_wr(input int id, input logic awv, input logic wv, input logic bv,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (id == 0) begin
      s0_awvalid = awv; s0_wvalid = wv; s0_bready = bv;
      s0_awaddr = a; s0_wdata = d; s0_wstrb = s;
    end else begin
      s1_awvalid = awv; s1_wvalid = wv; s1_bready = bv;
      s1_awaddr = a; s1_wdata = d; s1_wstrb = s;
    end
  endtask

  task automatic do_write(input int id, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp, output logic gnt,
                          output int aw_c, output int w_c, output int b_c, output bit ok);
    logic aw_p, w_p, a, w, b;
    aw_p = 1'b1; w_p = 1'b1; ok = 1'b0; resp = '0; gnt = 1'b0;
    aw_c = -1; w_c = -1; b_c = -1;
    set_wr(id, 1'b1, 1'b1, 1'b1, addr, data, strb);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      check("wr_other_side_quiet", side_out(1 - id), 0);
      a = aw_p && ((id == 0) ? s0_awready : s1_awready);
      w = w_p && ((id == 0) ? s0_wready : s1_wready);
      b = (id == 0) ? s0_bvalid : s1_bvalid;
      if (a) aw_c = c;
      if (w) begin w_c = c; gnt = grant_id; end
      if (b) begin b_c = c; resp = (id == 0) ? s0_bresp : s1_bresp; ok = 1'b1; end
      @(posedge clk); #1;
      if (a) aw_p = 1'b0;
      if (w) w_p = 1'b0;
      set_wr(id, aw_p, w_p, !b, aw_p ? addr : '0, w_p ? data : '0, w_p ? strb : '0);
      if (b) break;
    end
    if (!ok) begin
      set_wr(id, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      note_timeout("wr_b");
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    int          id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  resp;      // slave response, must arrive unchanged
    int          exp_busy;  // cycles with busy high
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd1;
    logic [1:0]  rs, rs1;
    logic        g, g1;
    bit          ok, ok1;
    int          aw_c, w_c, b_c, base, nar0, naw0, nw0, bb, gb, mx;

    vecs[0] = '{1'b0, 0, 32'h1000_0004, 32'hDEAD_BEEF, 4'h0, 0, 0, 2'b00, 3};
    vecs[1] = '{1'b0, 1, 32'h2000_0010, 32'h1234_5678, 4'h0, 0, 0, 2'b10, 3};
    vecs[2] = '{1'b1, 1, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 3, 0, 2'b00, 5};
    vecs[3] = '{1'b1, 0, 32'h4000_0008, 32'h0BAD_F00D, 4'h3, 0, 0, 2'b10, 2};
    vecs[4] = '{1'b1, 0, 32'h5000_000C, 32'h1357_9BDF, 4'hC, 0, 2, 2'b11, 4};
    vecs[5] = '{1'b0, 0, 32'h6000_0020, 32'hCAFE_F00D, 4'h0, 0, 0, 2'b11, 3};

    checks = 0; errors = 0;
    busy_cnt = 0; busy_prev = 1'b0; n_ar = 0; n_aw = 0; n_w = 0;
    aw_delay = 0; w_delay = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
    s0_awaddr = '0; s0_awvalid = 0; s0_wdata = '0; s0_wstrb = '0; s0_wvalid = 0; s0_bready = 0;
    s0_araddr = '0; s0_arvalid = 0; s0_rready = 0;
    s1_awaddr = '0; s1_awvalid = 0; s1_wdata = '0; s1_wstrb = '0; s1_wvalid = 0; s1_bready = 0;
    s1_araddr = '0; s1_arvalid = 0; s1_rready = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("outputs_zero_in_reset", any_out(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("outputs_zero_after_reset", any_out(), 0);
    check("grant_after_reset", grant_id, 0);
    @(posedge clk); #1;

    // Tie from reset: s0, then s1, then a fresh tie back to s0
    cfg_rdata = 32'h1111_2222;
    base = glog.size();
    fork
      do_read(0, 32'h0000_0100, 1'b0, rd, rs, g, ok);
      do_read(1, 32'h0000_0200, 1'b0, rd1, rs1, g1, ok1);
    join
    check("tie1_s0_data", rd, 32'h1111_2222);
    check("tie1_s1_data", rd1, 32'h1111_2222);
    check("tie1_s0_grant", g, 0);
    check("tie1_s1_grant", g1, 1);
    fork
      do_read(0, 32'h0000_0300, 1'b0, rd, rs, g, ok);
      do_read(1, 32'h0000_0400, 1'b0, rd1, rs1, g1, ok1);
    join
    check("tie_log_len", glog.size() - base, 4);
    if (glog.size() - base >= 3) begin
      check("tie_grant_seq0", glog[base], 0);
      check("tie_grant_seq1", glog[base+1], 1);
      check("tie_grant_seq2", glog[base+2], 0);
    end

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      aw_delay = vecs[i].aw_dly; w_delay = vecs[i].w_dly;
      cfg_bresp = vecs[i].resp; cfg_rresp = vecs[i].resp; cfg_rdata = vecs[i].data;
      nar0 = n_ar; naw0 = n_aw; nw0 = n_w; bb = busy_cnt; gb = glog.size();
      if (!vecs[i].wr) begin
        do_read(vecs[i].id, vecs[i].addr, 1'b1, rd, rs, g, ok);
        check($sformatf("v%0d_rdata", i), rd, vecs[i].data);
        check($sformatf("v%0d_rresp", i), rs, vecs[i].resp);
        check($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].addr);
      end else begin
        do_write(vecs[i].id, vecs[i].addr, vecs[i].data, vecs[i].strb, rs, g, aw_c, w_c, b_c,
                 ok);
        mx = (aw_c > w_c) ? aw_c : w_c;
        check($sformatf("v%0d_bresp", i), rs, vecs[i].resp);
        check($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].addr);
        check($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].data);
        check($sformatf("v%0d_wstrb", i), cap_wstrb, vecs[i].strb);
        check($sformatf("v%0d_aw_w_gap", i), aw_c - w_c, vecs[i].aw_dly - vecs[i].w_dly);
        check($sformatf("v%0d_resp_next_cycle", i), b_c, mx + 1);
      end
      check($sformatf("v%0d_grant", i), g, vecs[i].id);
      repeat (2) @(posedge clk);
      #2;
      check($sformatf("v%0d_idle_after", i), busy, 0);
      check($sformatf("v%0d_busy_cycles", i), busy_cnt - bb, vecs[i].exp_busy);
      check($sformatf("v%0d_ar_count", i), n_ar - nar0, vecs[i].wr ? 0 : 1);
      check($sformatf("v%0d_aw_count", i), n_aw - naw0, vecs[i].wr ? 1 : 0);
      check($sformatf("v%0d_w_count", i), n_w - nw0, vecs[i].wr ? 1 : 0);
      check($sformatf("v%0d_one_grant", i), glog.size() - gb, 1);
      @(posedge clk); #1;
    end

    // Reset while in RD_DATA, then a clean s1 read
    cfg_rdata = 32'h7777_8888; cfg_rresp = 2'b00;
    set_ar(0, 1'b1, 32'h0000_0500);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s0_arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    set_ar(0, 1'b0, '0);
    if (!ok) note_timeout("rst_mid_ar");
    @(negedge clk);
    check("rst_mid_in_rd_data", {busy, m_rready, m_rvalid}, 3'b101);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outputs_zero", any_out(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs_zero_after", any_out(), 0);
    check("rst_mid_grant", grant_id, 0);
    @(posedge clk); #1;
    cfg_rdata = 32'h600D_CAFE;
    do_read(1, 32'h0000_0600, 1'b1, rd, rs, g, ok);
    check("post_rst_s1_rdata", rd, 32'h600D_CAFE);
    check("post_rst_s1_rresp", rs, 2'b00);
    check("post_rst_s1_grant", g, 1);
    check("post_rst_araddr", cap_araddr, 32'h0000_0600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/holy_axi_lite_arbiter.md
HOLY_AXI_LITE_ARBITER -- requirements
Module: holy_axi_lite_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all AW/AR channels.
REQ-002 Parameter DATA_W, default 32: data width; strobe width is DATA_W/8.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Ports s0_* and s1_*, slave side, one set per requester (0 = core data path, 1 = debug module): awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready as inputs; awready, wready, bresp[1:0], bvalid, arready, rdata, rresp[1:0], rvalid as outputs.
REQ-006 Ports m_axi_lite_*, master side, one AXI-Lite master with the same channel set and the opposite directions.
REQ-007 Port busy, output, 1: high whenever the state is not IDLE.
REQ-008 Port grant_id, output, 1: index of the requester that owns the current transaction.

Function
REQ-009 The FSM SHALL have the states IDLE, RD_ADDR, RD_DATA, WR_XFER and WR_RESP; only one transaction is outstanding at a time.
REQ-010 IDLE: a requester is a candidate if its arvalid or awvalid is high; the grant is registered, so forwarding starts on the cycle after the decision.
REQ-011 Arbitration SHALL be round-robin: with both requesters as candidates, the one not in last_id wins; a single candidate wins outright.
REQ-012 If the winner has both arvalid and awvalid high, the read is served first (IDLE -> RD_ADDR); otherwise awvalid moves to WR_XFER.
REQ-013 RD_ADDR: forward araddr/arvalid of the granted requester and return arready; on m_axi_lite_arvalid & arready go to RD_DATA.
REQ-014 RD_DATA: forward rdata/rresp/rvalid and return rready; on the R handshake go to IDLE and set last_id to grant_id.
REQ-015 WR_XFER: forward AW and W independently; per-transaction flags aw_done/w_done are set on each handshake, and each valid is masked once its flag is set.
REQ-016 WR_XFER goes to WR_RESP when both channels are done, including when both handshakes fall in the same cycle.
REQ-017 WR_RESP: forward bresp/bvalid and return bready; on the B handshake go to IDLE, set last_id, and clear both flags.
REQ-018 The non-granted requester SHALL see every ready and every response valid at 0, and its data/response outputs at 0.
REQ-019 In IDLE all master-side valids and readies SHALL be 0, and all slave-side readies and response valids SHALL be 0.
REQ-020 Ready/valid forwarding within a granted phase is combinational, adding zero cycles; total overhead is one arbitration cycle per transaction.
REQ-021 SLVERR and DECERR responses pass through unchanged; the arbiter SHALL NOT retry.
REQ-022 A requester that drops valid before its handshake is a protocol violation; behaviour is unspecified and covered by an assertion in the bench.
REQ-023 No timeout: the FSM waits indefinitely for the downstream response.

Reset
REQ-024 When rst is high at a clock edge: state = IDLE, last_id = 1 (so requester 0 wins the first tie), aw_done = w_done = 0, grant_id = 0.
REQ-025 During and after reset all outputs SHALL be 0 (busy, valids, readies, data).
REQ-026 Reset during an active transaction abandons it with no completion to the requester; the downstream slave is reset by the same system reset.

Structure
REQ-027 The state enum (arb_state_t) and the width of the AXI response field SHALL live in the shared package holy_axi_pkg.
REQ-028 The block is one module with no sub-modules; the round-robin pick is inline combinational logic.
REQ-029 The RTL is expected to be roughly 150-250 lines.

Verification
REQ-030 Read: s0 reads 0x1000_0004, slave returns 0xDEADBEEF with OKAY -> s0 rdata = 0xDEADBEEF; s1 sees no ready or valid; busy high for exactly 3 cycles with a zero-wait slave.
REQ-031 Tie: s0 and s1 both assert arvalid from reset -> s0 is served first, then s1, then a new tie goes to s0 again; grant_id sequence is 0,1,0.
REQ-032 Split write: s1 writes 0xA5A5A5A5 with wstrb 0xF, W handshake 3 cycles before AW -> exactly one AW and one W downstream, then B OKAY returned to s1 only.
REQ-033 Simultaneous AW/W handshake in one cycle -> WR_RESP on the next cycle, with no duplicate handshake.
REQ-034 Error: slave returns bresp = 2'b10 -> s0 receives bresp = 2'b10, the FSM returns to IDLE, and there is no retry.
REQ-035 Reset mid-operation: rst asserted in RD_DATA -> the next cycle has state IDLE and all outputs 0; a subsequent s1 read completes normally.
